uart_reg_responder: RTL and testbench
=====================================

// Module: uart_reg_responder
// PURPOSE
//  Host-command responder on the byte side of the UART controller. Parses command
//  frames from the receive byte stream and performs 8-bit register bus reads/writes.
//  Returns one response byte per frame through the transmit byte handshake.
//  Gives a PC-side initiator register access to the design over rx/tx.
// PARAMETERS
//  ADDR_W   4      register address width; valid addresses 0 .. 2**ADDR_W-1
//  TIMEOUT  20000  clk cycles allowed between bytes of one frame
// PORTS
//  clk        in   1       system clock
//  rst        in   1       asynchronous reset, active-low
//  rx_data    in   8       received byte (UART dout)
//  rx_valid   in   1       1-cycle pulse, rx_data valid (UART dout_rdy)
//  tx_data    out  8       byte to send (UART din)
//  tx_valid   out  1       1-cycle send strobe (UART din_rdy)
//  tx_ready   in   1       transmitter idle (UART tx_rdy)
//  reg_addr   out  ADDR_W  register bus address
//  reg_wdata  out  8       register bus write data
//  reg_we     out  1       1-cycle write strobe
//  reg_re     out  1       1-cycle read strobe; reg_rdata valid the following cycle
//  reg_rdata  in   8       register bus read data
//  busy       out  1       high in every state except IDLE
//  err_cnt    out  8       saturating error counter (NAK, timeout, overrun)
// BEHAVIOUR
//  Reset (rst=0): state IDLE; tx_data, reg_addr, reg_wdata, err_cnt = 0;
//   tx_valid, reg_we, reg_re, busy = 0. Bus and UART strobes are all registered.
//  Frames: 'W'(0x57) ADDR DATA -> write, response 0x06 (ACK).
//   'R'(0x52) ADDR -> read, response = reg_rdata. Any other first byte -> 0x15 (NAK).
//  ADDR >= 2**ADDR_W: frame fully consumed, no bus strobe, response NAK.
//  States:
//   IDLE     rx_valid: 'W'/'R' -> GET_ADDR (opcode latched); other -> SEND with NAK.
//   GET_ADDR rx_valid -> bad addr: SEND(NAK) for 'R', GET_DATA for 'W';
//            good addr: REG_RD for 'R', GET_DATA for 'W'.
//   GET_DATA rx_valid -> data latched; REG_WR if addr good, else SEND(NAK).
//   REG_WR   reg_we=1 for one cycle -> SEND(ACK).
//   REG_RD   reg_re=1 for one cycle -> RD_CAP.
//   RD_CAP   latch reg_rdata into tx_data -> SEND.
//   SEND     wait tx_ready=1; then tx_valid=1 for one cycle -> TX_HOLD.
//   TX_HOLD  one cycle, tx_ready ignored -> IDLE.
//  Latency: 'R' final byte pulse to tx_valid = 4 cycles when tx_ready already high;
//   'W' DATA pulse to tx_valid = 3 cycles.
//  Timeout: counter clears on every accepted byte and on entry to GET_ADDR; in
//   GET_ADDR/GET_DATA, after TIMEOUT cycles with no rx_valid -> IDLE, no response,
//   no bus strobe, err_cnt+1.
//  Overrun: rx_valid in REG_WR, REG_RD, RD_CAP, SEND or TX_HOLD -> byte dropped,
//   err_cnt+1; frame in progress continues unaffected.
//  err_cnt: +1 per NAK sent, timeout or overrun; saturates at 255, never wraps;
//   cleared only by reset. Simultaneous events in one cycle count once.
//  reg_addr/reg_wdata hold their last values between frames.
//  Reset mid-frame or mid-send: immediate return to reset values; a partial frame
//   is discarded, no response is sent.
// TESTING
//  1. 0x57,0x03,0xA5 -> one reg_we pulse, reg_addr=3, reg_wdata=0xA5; tx_data=0x06.
//  2. reg_rdata=0x3C; 0x52,0x07 -> one reg_re pulse, addr=7; tx_data=0x3C,
//     tx_valid 4 cycles after the ADDR pulse.
//  3. 0x41 -> tx_data=0x15, err_cnt=1; 0x52,0x10 (ADDR_W=4) -> NAK, no reg_re.
//  4. 0x57,0x01 then idle TIMEOUT cycles -> IDLE, no tx_valid, no reg_we, err_cnt+1.
//  5. tx_ready held 0 during response, extra byte sent -> overrun counted, response
//     sent once after tx_ready=1.
//  6. 300 invalid opcodes -> err_cnt=255; rst=0 mid 'R' frame -> all outputs 0, no tx.

Source files
------------

// File: rtl/uart_reg_responder.sv
// Command-frame responder on the byte side of a UART.
// 'W' ADDR DATA performs a register write and replies ACK. 'R' ADDR performs a
// register read and replies with the read data. Anything else gets a NAK.
// Exactly one response byte is returned per frame.
module uart_reg_responder #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned TIMEOUT = 20000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              busy,
  output logic [7:0]        err_cnt
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  localparam logic [7:0] OpWr = 8'h57;
  localparam logic [7:0] OpRd = 8'h52;
  localparam logic [7:0] Ack  = 8'h06;
  localparam logic [7:0] Nak  = 8'h15;

  typedef enum logic [2:0] {
    StIdle, StGetAddr, StGetData, StRegWr, StRegRd, StRdCap, StSend, StTxHold
  } state_e;

  state_e        state;
  logic          op_wr;     // latched opcode: 1 = write, 0 = read
  logic          addr_bad;  // latched address range result for the data phase
  logic [TW-1:0] tmo_cnt;

  logic addr_bad_now;
  logic overrun;
  logic tmo_hit;
  logic nak_now;
  logic err_inc;

  // Error-event decode; at most one event source can fire in a given state.
  always_comb begin
    addr_bad_now = (rx_data >> ADDR_W) != 8'd0;
    overrun      = rx_valid && (state inside {StRegWr, StRegRd, StRdCap, StSend, StTxHold});
    tmo_hit      = !rx_valid && (state inside {StGetAddr, StGetData}) &&
                   (tmo_cnt == TW'(TIMEOUT - 1));
    nak_now      = rx_valid &&
                   ((state == StIdle && rx_data != OpWr && rx_data != OpRd) ||
                    (state == StGetAddr && !op_wr && addr_bad_now) ||
                    (state == StGetData && addr_bad));
    err_inc      = overrun || tmo_hit || nak_now;
  end

  assign busy = (state != StIdle);

  // Frame parser, bus sequencer and response sender with registered strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= StIdle;
      op_wr     <= 1'b0;
      addr_bad  <= 1'b0;
      tmo_cnt   <= '0;
      tx_data   <= 8'd0;
      tx_valid  <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= 8'd0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      err_cnt   <= 8'd0;
    end else begin
      tx_valid <= 1'b0;
      reg_we   <= 1'b0;
      reg_re   <= 1'b0;
      if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;

      unique case (state)
        StIdle: begin
          if (rx_valid) begin
            if (rx_data == OpWr || rx_data == OpRd) begin
              op_wr   <= (rx_data == OpWr);
              tmo_cnt <= '0;
              state   <= StGetAddr;
            end else begin
              tx_data <= Nak;
              state   <= StSend;
            end
          end
        end
        StGetAddr: begin
          if (rx_valid) begin
            tmo_cnt  <= '0;
            addr_bad <= addr_bad_now;
            if (!addr_bad_now) reg_addr <= rx_data[ADDR_W-1:0];
            if (op_wr) begin
              state <= StGetData;
            end else if (addr_bad_now) begin
              tx_data <= Nak;
              state   <= StSend;
            end else begin
              reg_re <= 1'b1;
              state  <= StRegRd;
            end
          end else if (tmo_hit) begin
            state <= StIdle;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        StGetData: begin
          if (rx_valid) begin
            tmo_cnt   <= '0;
            reg_wdata <= rx_data;
            if (addr_bad) begin
              tx_data <= Nak;
              state   <= StSend;
            end else begin
              reg_we <= 1'b1;
              state  <= StRegWr;
            end
          end else if (tmo_hit) begin
            state <= StIdle;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        StRegWr: begin
          tx_data <= Ack;
          state   <= StSend;
        end
        StRegRd: state <= StRdCap;
        StRdCap: begin
          tx_data <= reg_rdata;
          state   <= StSend;
        end
        StSend: begin
          if (tx_ready) begin
            tx_valid <= 1'b1;
            state    <= StTxHold;
          end
        end
        StTxHold: state <= StIdle;
        default:  state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_reg_responder.sv
// Directed bench for uart_reg_responder with hand-computed expectations.
module tb_uart_reg_responder;

  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [7:0]        rx_data = 8'd0;
  logic              rx_valid = 1'b0;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b1;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [7:0]        reg_rdata = 8'h3C;
  logic              busy;
  logic [7:0]        err_cnt;

  uart_reg_responder #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .busy      (busy),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitors, sampled mid-cycle on the falling edge.
  int         we_cnt = 0;
  int         re_cnt = 0;
  int         tx_cnt = 0;
  int         tx_cyc = 0;
  logic [7:0] last_tx = 8'd0;
  logic [7:0] we_addr = 8'd0;
  logic [7:0] we_data = 8'd0;
  logic [7:0] re_addr = 8'd0;
  always @(negedge clk) begin
    if (reg_we) begin
      we_cnt  <= we_cnt + 1;
      we_addr <= 8'(reg_addr);
      we_data <= reg_wdata;
    end
    if (reg_re) begin
      re_cnt  <= re_cnt + 1;
      re_addr <= 8'(reg_addr);
    end
    if (tx_valid) begin
      tx_cnt  <= tx_cnt + 1;
      last_tx <= tx_data;
      tx_cyc  <= cyc;
    end
  end

  int n_chk  = 0;
  int n_fail = 0;
  int rx_cyc = 0;
  int we0, re0, tx0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One-cycle rx_valid pulse; rx_cyc marks the cycle the pulse starts.
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    rx_cyc   = cyc;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic snap();
    @(negedge clk);
    we0 = we_cnt;
    re0 = re_cnt;
    tx0 = tx_cnt;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_reg_addr", 32'(reg_addr), 32'd0);
    check("rst_reg_wdata", 32'(reg_wdata), 32'd0);
    check("rst_strobes", 32'({reg_we, reg_re}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst = 1'b1;

    // Write frame: ACK three cycles after the DATA pulse
    snap();
    send_byte(8'h57); send_byte(8'h03); send_byte(8'hA5);
    wait_idle("wr_idle");
    @(negedge clk);
    check("wr_we_pulses", 32'(we_cnt - we0), 32'd1);
    check("wr_addr", 32'(we_addr), 32'h03);
    check("wr_data", 32'(we_data), 32'hA5);
    check("wr_tx_count", 32'(tx_cnt - tx0), 32'd1);
    check("wr_tx_data", 32'(last_tx), 32'h06);
    check("wr_latency", 32'(tx_cyc - rx_cyc), 32'd3);
    check("wr_err", 32'(err_cnt), 32'd0);

    // Read frame: read data returned four cycles after the ADDR pulse
    snap();
    send_byte(8'h52); send_byte(8'h07);
    wait_idle("rd_idle");
    @(negedge clk);
    check("rd_re_pulses", 32'(re_cnt - re0), 32'd1);
    check("rd_addr", 32'(re_addr), 32'h07);
    check("rd_tx_data", 32'(last_tx), 32'h3C);
    check("rd_latency", 32'(tx_cyc - rx_cyc), 32'd4);
    check("rd_no_we", 32'(we_cnt - we0), 32'd0);

    // Bad opcode and out-of-range addresses
    snap();
    send_byte(8'h41);
    wait_idle("nak_idle");
    @(negedge clk);
    check("nak_tx_data", 32'(last_tx), 32'h15);
    check("nak_err", 32'(err_cnt), 32'd1);
    send_byte(8'h52); send_byte(8'h10);
    wait_idle("badrd_idle");
    @(negedge clk);
    check("badrd_tx_data", 32'(last_tx), 32'h15);
    check("badrd_no_re", 32'(re_cnt - re0), 32'd0);
    check("badrd_err", 32'(err_cnt), 32'd2);
    send_byte(8'h57); send_byte(8'h1F); send_byte(8'h55);
    wait_idle("badwr_idle");
    @(negedge clk);
    check("badwr_tx_data", 32'(last_tx), 32'h15);
    check("badwr_no_we", 32'(we_cnt - we0), 32'd0);
    check("badwr_addr_held", 32'(reg_addr), 32'h07);
    check("badwr_err", 32'(err_cnt), 32'd3);
    check("bad_tx_count", 32'(tx_cnt - tx0), 32'd3);

    // Timeout in the data phase
    snap();
    send_byte(8'h57); send_byte(8'h01);
    repeat (TIMEOUT - 2) @(posedge clk);
    #1;
    check("tmo_still_busy", 32'(busy), 32'd1);
    repeat (6) @(posedge clk);
    #1;
    check("tmo_idle", 32'(busy), 32'd0);
    check("tmo_no_tx", 32'(tx_cnt - tx0), 32'd0);
    check("tmo_no_we", 32'(we_cnt - we0), 32'd0);
    check("tmo_err", 32'(err_cnt), 32'd4);

    // Response stalled by tx_ready, with an overrun byte during the stall
    tx_ready = 1'b0;
    snap();
    send_byte(8'h52); send_byte(8'h07);
    repeat (5) @(posedge clk);
    send_byte(8'h99);
    repeat (3) @(posedge clk);
    #1;
    check("stall_busy", 32'(busy), 32'd1);
    check("stall_no_tx", 32'(tx_cnt - tx0), 32'd0);
    check("ovr_err", 32'(err_cnt), 32'd5);
    tx_ready = 1'b1;
    wait_idle("stall_idle");
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("stall_tx_once", 32'(tx_cnt - tx0), 32'd1);
    check("stall_tx_data", 32'(last_tx), 32'h3C);
    check("stall_re_once", 32'(re_cnt - re0), 32'd1);
    check("stall_err", 32'(err_cnt), 32'd5);

    // Saturation of err_cnt
    for (int i = 0; i < 300; i++) begin
      send_byte(8'h41);
      wait_idle("sat_idle");
    end
    check("sat_err", 32'(err_cnt), 32'd255);

    // Reset in the middle of a read frame
    snap();
    send_byte(8'h52);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_err", 32'(err_cnt), 32'd0);
    check("mid_rst_outs", 32'({tx_data, reg_wdata, 4'(reg_addr)}), 32'd0);
    check("mid_rst_strobes", 32'({tx_valid, reg_we, reg_re}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("mid_rst_no_tx", 32'(tx_cnt - tx0), 32'd0);
    check("mid_rst_no_re", 32'(re_cnt - re0), 32'd0);
    check("mid_rst_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
